// File: rtl/mux_scan_ctrl_if.sv
// Signal bundle between mux_scan_ctrl and the SN54LS153 it drives.
// master: the sequencer (drives select/strobes/results, reads start and mux outputs).
// slave : the environment (mux model + requester).
interface mux_scan_ctrl_if;
   logic       i_start;   // scan request
   logic       o_busy;    // sequencer not idle
   logic       o_B;       // mux select MSB
   logic       o_A;       // mux select LSB
   logic       o_1G_n;    // strobe, mux half 1, active low
   logic       o_2G_n;    // strobe, mux half 2, active low
   logic       i_1Y;      // mux half 1 output
   logic       i_2Y;      // mux half 2 output
   logic [3:0] o_data1;   // last completed scan, half 1 (bit k = 1Ck)
   logic [3:0] o_data2;   // last completed scan, half 2 (bit k = 2Ck)
   logic       o_valid;   // one-cycle pulse when o_data1/o_data2 update

   modport master (
      input  i_start, i_1Y, i_2Y,
      output o_busy, o_B, o_A, o_1G_n, o_2G_n, o_data1, o_data2, o_valid
   );

   modport slave (
      output i_start, i_1Y, i_2Y,
      input  o_busy, o_B, o_A, o_1G_n, o_2G_n, o_data1, o_data2, o_valid
   );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scans all four channels of both LS153 halves and reports them as two 4-bit words.
// Start-to-valid latency is 4*(SETTLE_CYC+1) cycles; o_valid is a one-cycle pulse.
// No backpressure: i_start is honoured only in IDLE, requests while busy are dropped.
//
// Ports: i_clk, i_rst (async, active high), bus (mux_scan_ctrl_if.master): start/busy,
// select lines o_B/o_A, strobes o_1G_n/o_2G_n, mux outputs i_1Y/i_2Y, results o_data1/
// o_data2 with o_valid.
// Build option: define MUX_SCAN_AUTO_EN for continuous rescanning after the first start.
module mux_scan_ctrl #(
   parameter int unsigned SETTLE_CYC = 2   // strobe-low cycles per channel, 1..15
) (
   input  logic           i_clk,
   input  logic           i_rst,
   mux_scan_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SELECT = 2'd1,
      SETTLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

   state_t     state, state_nxt;
   logic [1:0] ch, ch_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [3:0] sh1, sh1_nxt;
   logic [3:0] sh2, sh2_nxt;

   logic       busy_q, b_q, a_q, g1_n_q, g2_n_q, valid_q;
   logic [3:0] data1_q, data2_q;

   // Output values for the state being entered; registering them keeps the
   // strobes and selects glitch-free and free of any input-to-output path.
   logic       scanning_nxt;
   logic [1:0] sel_nxt;
   logic       strobe_n_nxt;
   logic       done_nxt;

   always_comb begin
      state_nxt = state;
      ch_nxt    = ch;
      cnt_nxt   = cnt;
      sh1_nxt   = sh1;
      sh2_nxt   = sh2;
      case (state)
         IDLE: begin
            if (bus.i_start) begin
               ch_nxt    = 2'd0;
               state_nxt = SELECT;
            end
         end
         SELECT: begin
            cnt_nxt   = 4'd0;
            state_nxt = SETTLE;
         end
         SETTLE: begin
            if (cnt == SETTLE_LAST) begin
               // Mux outputs are only trusted at the end of the settle window.
               sh1_nxt[ch] = bus.i_1Y;
               sh2_nxt[ch] = bus.i_2Y;
               if (ch == 2'd3) begin
                  state_nxt = DONE;
               end else begin
                  ch_nxt    = ch + 2'd1;
                  state_nxt = SELECT;
               end
            end else begin
               cnt_nxt = cnt + 4'd1;
            end
         end
         DONE: begin
`ifdef MUX_SCAN_AUTO_EN
            ch_nxt    = 2'd0;
            state_nxt = SELECT;
`else
            state_nxt = IDLE;
`endif
         end
         default: state_nxt = IDLE;
      endcase

      scanning_nxt = (state_nxt == SELECT) || (state_nxt == SETTLE);
      sel_nxt      = scanning_nxt ? ch_nxt : 2'b00;
      // Strobes drop only in SETTLE, so SELECT gives break-before-make.
      strobe_n_nxt = (state_nxt != SETTLE);
      done_nxt     = (state_nxt == DONE);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= IDLE;
         ch      <= 2'd0;
         cnt     <= 4'd0;
         sh1     <= 4'h0;
         sh2     <= 4'h0;
         busy_q  <= 1'b0;
         b_q     <= 1'b0;
         a_q     <= 1'b0;
         g1_n_q  <= 1'b1;
         g2_n_q  <= 1'b1;
         valid_q <= 1'b0;
         data1_q <= 4'h0;
         data2_q <= 4'h0;
      end else begin
         state   <= state_nxt;
         ch      <= ch_nxt;
         cnt     <= cnt_nxt;
         sh1     <= sh1_nxt;
         sh2     <= sh2_nxt;
         busy_q  <= (state_nxt != IDLE);
         b_q     <= sel_nxt[1];
         a_q     <= sel_nxt[0];
         g1_n_q  <= strobe_n_nxt;
         g2_n_q  <= strobe_n_nxt;
         valid_q <= done_nxt;
         // DONE is only ever entered from the last SETTLE cycle, so the
         // shadow values here already include the channel-3 capture.
         if (done_nxt) begin
            data1_q <= sh1_nxt;
            data2_q <= sh2_nxt;
         end
      end
   end

   assign bus.o_busy  = busy_q;
   assign bus.o_B     = b_q;
   assign bus.o_A     = a_q;
   assign bus.o_1G_n  = g1_n_q;
   assign bus.o_2G_n  = g2_n_q;
   assign bus.o_valid = valid_q;
   assign bus.o_data1 = data1_q;
   assign bus.o_data2 = data2_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
module tb_mux_scan_ctrl;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   // Channel inputs of the two behavioural LS153s (dut2: SETTLE_CYC=2, dut1: SETTLE_CYC=1)
   logic [3:0] c1_a, c2_a, c1_b, c2_b;

   mux_scan_ctrl_if if2 ();
   mux_scan_ctrl_if if1 ();

   mux_scan_ctrl #(.SETTLE_CYC(2)) u_dut2 (.i_clk(clk), .i_rst(rst), .bus(if2));
   mux_scan_ctrl #(.SETTLE_CYC(1)) u_dut1 (.i_clk(clk), .i_rst(rst), .bus(if1));

   // LS153: output follows the selected channel while strobed, else low.
   assign if2.i_1Y = ~if2.o_1G_n & c1_a[{if2.o_B, if2.o_A}];
   assign if2.i_2Y = ~if2.o_2G_n & c2_a[{if2.o_B, if2.o_A}];
   assign if1.i_1Y = ~if1.o_1G_n & c1_b[{if1.o_B, if1.o_A}];
   assign if1.i_2Y = ~if1.o_2G_n & c2_b[{if1.o_B, if1.o_A}];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Pulse i_start on dut2 and count edges until the first o_valid (bounded).
   task automatic scan2(input int ncyc, output int first_v, output int nv);
      @(negedge clk) if2.i_start = 1'b1;
      @(posedge clk);
      #1 if2.i_start = 1'b0;
      first_v = -1;
      nv = 0;
      for (int n = 1; n <= ncyc; n++) begin
         @(posedge clk); #1;
         if (if2.o_valid) begin
            nv++;
            if (first_v < 0) first_v = n;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk) if2.i_start = 1'b1;
      @(posedge clk);
      #1 if2.i_start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (if2.o_busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %b want 1", if2.o_busy); end
      #2 rst = 1'b1;   // mid-cycle, well before the next edge
      #1;
      checks++; if (if2.o_busy  !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", if2.o_busy); end
      checks++; if (if2.o_B     !== 1'b0) begin errors++; $display("FAIL rst_B got %b want 0", if2.o_B); end
      checks++; if (if2.o_A     !== 1'b0) begin errors++; $display("FAIL rst_A got %b want 0", if2.o_A); end
      checks++; if (if2.o_1G_n  !== 1'b1) begin errors++; $display("FAIL rst_1G_n got %b want 1", if2.o_1G_n); end
      checks++; if (if2.o_2G_n  !== 1'b1) begin errors++; $display("FAIL rst_2G_n got %b want 1", if2.o_2G_n); end
      checks++; if (if2.o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", if2.o_valid); end
      checks++; if (if2.o_data1 !== 4'h0) begin errors++; $display("FAIL rst_data1 got %h want 0", if2.o_data1); end
      checks++; if (if2.o_data2 !== 4'h0) begin errors++; $display("FAIL rst_data2 got %h want 0", if2.o_data2); end
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [1:0] seq[$];
      logic [1:0] prev_sel, cur;
      int first_v, nv;
      c1_a = 4'b1010;
      c2_a = 4'b0110;
      @(negedge clk) if2.i_start = 1'b1;
      @(posedge clk);
      #1 if2.i_start = 1'b0;
      first_v = -1; nv = 0; prev_sel = 2'b00;
      for (int n = 0; n <= 20; n++) begin
         if (n > 0) begin @(posedge clk); #1; end
         cur = {if2.o_B, if2.o_A};
         if (cur !== prev_sel) begin
            checks++;
            if (!(if2.o_1G_n === 1'b1 && if2.o_2G_n === 1'b1)) begin
               errors++;
               $display("FAIL basic_bbm n=%0d strobes %b%b want 11", n, if2.o_1G_n, if2.o_2G_n);
            end
         end
         if (if2.o_1G_n === 1'b0 && (seq.size() == 0 || seq[$] !== cur)) seq.push_back(cur);
         if (if2.o_valid === 1'b1) begin
            nv++;
            if (first_v < 0) first_v = n;
         end
         prev_sel = cur;
      end
      checks++; if (first_v != 12) begin errors++; $display("FAIL basic_latency got %0d want 12", first_v); end
      checks++; if (nv != 1) begin errors++; $display("FAIL basic_valid_count got %0d want 1", nv); end
      checks++; if (if2.o_data1 !== 4'b1010) begin errors++; $display("FAIL basic_data1 got %b want 1010", if2.o_data1); end
      checks++; if (if2.o_data2 !== 4'b0110) begin errors++; $display("FAIL basic_data2 got %b want 0110", if2.o_data2); end
      checks++; if (if2.o_busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b want 0", if2.o_busy); end
      checks++;
      if (seq.size() != 4) begin
         errors++; $display("FAIL basic_sel_count got %0d want 4", seq.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (seq[i] !== 2'(i)) begin errors++; $display("FAIL basic_sel_seq[%0d] got %b want %b", i, seq[i], 2'(i)); end
         end
      end
   endtask

   task automatic test_settle_boundary();
      int first_v;
      c1_b = 4'b1001;
      c2_b = 4'b0101;
      @(negedge clk) if1.i_start = 1'b1;
      @(posedge clk);
      #1 if1.i_start = 1'b0;
      first_v = -1;
      for (int n = 1; n <= 15; n++) begin
         @(posedge clk); #1;
         if (n == 4) begin
            checks++;
            if ({if1.o_B, if1.o_A, if1.o_1G_n} !== 3'b101) begin
               errors++; $display("FAIL settle_select_ch2 got %b want 101", {if1.o_B, if1.o_A, if1.o_1G_n});
            end
            c1_b[2] = 1'b1;
         end
         if (if1.o_valid === 1'b1 && first_v < 0) first_v = n;
      end
      checks++; if (first_v != 8) begin errors++; $display("FAIL settle_latency got %0d want 8", first_v); end
      checks++; if (if1.o_data1 !== 4'b1101) begin errors++; $display("FAIL settle_data1 got %b want 1101", if1.o_data1); end
      checks++; if (if1.o_data2 !== 4'b0101) begin errors++; $display("FAIL settle_data2 got %b want 0101", if1.o_data2); end
   endtask

   task automatic test_start_while_busy();
      int first_v, nv;
      c1_a = 4'b0011;
      c2_a = 4'b1100;
      @(negedge clk) if2.i_start = 1'b1;
      @(posedge clk);
      #1 if2.i_start = 1'b0;
      first_v = -1; nv = 0;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk); #1;
         if2.i_start = (n == 5 || n == 12);
         if (if2.o_valid === 1'b1) begin
            nv++;
            if (first_v < 0) first_v = n;
         end
      end
      if2.i_start = 1'b0;
      checks++; if (nv != 1) begin errors++; $display("FAIL busy_valid_count got %0d want 1", nv); end
      checks++; if (first_v != 12) begin errors++; $display("FAIL busy_latency got %0d want 12", first_v); end
      checks++; if (if2.o_busy !== 1'b0) begin errors++; $display("FAIL busy_back_idle got %b want 0", if2.o_busy); end
      checks++; if (if2.o_data1 !== 4'b0011) begin errors++; $display("FAIL busy_data1 got %b want 0011", if2.o_data1); end
   endtask

   task automatic test_reset_midscan();
      int first_v, nv;
      c1_a = 4'hF;
      c2_a = 4'h0;
      scan2(16, first_v, nv);
      checks++; if (if2.o_data1 !== 4'hF) begin errors++; $display("FAIL midrst_prior_data1 got %h want f", if2.o_data1); end
      c1_a = 4'b1100;
      @(negedge clk) if2.i_start = 1'b1;
      @(posedge clk);
      #1 if2.i_start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      checks++;
      if ({if2.o_B, if2.o_A} !== 2'b10) begin errors++; $display("FAIL midrst_at_ch2 got %b want 10", {if2.o_B, if2.o_A}); end
      #3 rst = 1'b1;
      #1;
      checks++; if (if2.o_data1 !== 4'h0) begin errors++; $display("FAIL midrst_data1 got %h want 0", if2.o_data1); end
      checks++; if (if2.o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", if2.o_busy); end
      @(negedge clk) rst = 1'b0;
      nv = 0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         if (if2.o_valid === 1'b1) nv++;
      end
      checks++; if (nv != 0) begin errors++; $display("FAIL midrst_spurious_valid got %0d want 0", nv); end
      scan2(16, first_v, nv);
      checks++; if (first_v != 12) begin errors++; $display("FAIL midrst_fresh_latency got %0d want 12", first_v); end
      checks++; if (if2.o_data1 !== 4'b1100) begin errors++; $display("FAIL midrst_fresh_data1 got %b want 1100", if2.o_data1); end
      checks++; if (if2.o_data2 !== 4'b0000) begin errors++; $display("FAIL midrst_fresh_data2 got %b want 0000", if2.o_data2); end
   endtask

`ifdef MUX_SCAN_AUTO_EN
   task automatic test_auto();
      logic [3:0] exp1[4];
      logic [3:0] exp2[4];
      int k;
      exp1 = '{4'b0101, 4'b1110, 4'b1110, 4'b1110};
      exp2 = '{4'b0011, 4'b0011, 4'b1000, 4'b1000};
      c1_a = 4'b0101;
      c2_a = 4'b0011;
      @(negedge clk) if2.i_start = 1'b1;
      @(posedge clk);
      #1 if2.i_start = 1'b0;
      k = 0;
      for (int n = 1; n <= 55; n++) begin
         @(posedge clk); #1;
         checks++;
         if (if2.o_busy !== 1'b1) begin errors++; $display("FAIL auto_busy n=%0d got %b want 1", n, if2.o_busy); end
         if (if2.o_valid === 1'b1) begin
            if (k < 4) begin
               checks++;
               if (n != 12 + 13 * k) begin errors++; $display("FAIL auto_period k=%0d got %0d want %0d", k, n, 12 + 13 * k); end
               checks++;
               if (if2.o_data1 !== exp1[k] || if2.o_data2 !== exp2[k]) begin
                  errors++;
                  $display("FAIL auto_data k=%0d got %b/%b want %b/%b", k, if2.o_data1, if2.o_data2, exp1[k], exp2[k]);
               end
            end
            k++;
            if (k == 1) c1_a = 4'b1110;
            if (k == 2) c2_a = 4'b1000;
         end
      end
      checks++; if (k != 4) begin errors++; $display("FAIL auto_valid_count got %0d want 4", k); end
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      if2.i_start = 1'b0;
      if1.i_start = 1'b0;
      c1_a = 4'h0; c2_a = 4'h0; c1_b = 4'h0; c2_b = 4'h0;
      #12 rst = 1'b0;
      test_reset();
`ifdef MUX_SCAN_AUTO_EN
      test_auto();
`else
      test_basic();
      test_settle_boundary();
      test_start_while_busy();
      test_reset_midscan();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencer that sits directly upstream of the SN54LS153 dual 4-to-1 multiplexer and scans all four channels of both halves. It drives the mux select lines (B, A) and both active-low strobes, and waits a programmable settle time per channel. It samples the two mux outputs (1Y, 2Y) and assembles them into two 4-bit words, then presents both words with a one-cycle valid pulse.

## Interface
- SETTLE_CYC, default 2: cycles the strobes are held low per channel before sampling. Legal range 1..15.
- i_clk  input  1  system clock; all logic on the rising edge.
- i_rst  input  1  asynchronous reset, active-high.
- i_start  input  1  scan request. Sampled in IDLE only.
- o_busy  output  1  high in every state except IDLE.
- o_B  output  1  mux select MSB, to i_B of the mux.
- o_A  output  1  mux select LSB, to i_A of the mux.
- o_1G_n  output  1  strobe for mux half 1, active low.
- o_2G_n  output  1  strobe for mux half 2, active low.
- i_1Y  input  1  output of mux half 1.
- i_2Y  input  1  output of mux half 2.
- o_data1  output  4  last completed scan of half 1; bit k = 1Ck.
- o_data2  output  4  last completed scan of half 2; bit k = 2Ck.
- o_valid  output  1  one-cycle pulse when o_data1/o_data2 update.

## Operation
- FSM states: IDLE, SELECT, SETTLE, DONE.
- Internal registers:
  - 2-bit channel counter ch.
  - 4-bit settle counter.
  - 4-bit shadow registers sh1 and sh2.
- Outputs in IDLE:
  - {o_B,o_A}=00.
  - Strobes high.
  - o_busy=0.
- IDLE: if i_start=1, clear ch to 0 and go to SELECT.
- SELECT (1 cycle):
  - {o_B,o_A}=ch.
  - Strobes held high, giving break-before-make on select changes.
  - Next state: SETTLE; settle counter loads 0.
- SETTLE (SETTLE_CYC cycles):
  - Select lines stay at ch; both strobes low.
  - At the edge ending the last SETTLE cycle, capture i_1Y into sh1[ch] and i_2Y into sh2[ch].
  - If ch==3, go to DONE; otherwise ch increments and the FSM returns to SELECT.
- DONE (1 cycle):
  - Strobes high.
  - o_data1/o_data2 load sh1/sh2 at the edge entering DONE, so they are visible with o_valid=1.
  - Next state: IDLE.
- Output holding:
  - o_data1/o_data2 hold their value between scans.
  - They change only on entry to DONE.
- i_start while busy, including the DONE cycle, is ignored. It is not queued.
- Select outputs and strobes are registered; no combinational path from inputs to outputs.

## Timing
- Reset value of every output:
  - o_busy=0, o_valid=0.
  - o_B=0, o_A=0.
  - o_1G_n=1, o_2G_n=1.
  - o_data1=4'h0, o_data2=4'h0.
- Per-channel cost: SETTLE_CYC+1 cycles.
- Latency from start to valid:
  - i_start is sampled high at edge E0.
  - o_valid is high in the cycle following edge E0+4·(SETTLE_CYC+1).
  - With the default (2), o_valid rises 12 cycles after E0.
- o_busy rises after E0 and falls after the edge that leaves DONE.
- Back-to-back scans: a new i_start is accepted no earlier than the first IDLE cycle after DONE.
- i_1Y/i_2Y are required to be stable by the final SETTLE cycle edge. Earlier values are not sampled.
- Reset asserted mid-scan:
  - Immediately forces IDLE and the reset values above.
  - Partial shadow data is discarded and o_data returns to 0.
  - No o_valid is produced for the aborted scan.

## Configuration
- Macro MUX_SCAN_AUTO_EN.
- Defined (continuous mode):
  - DONE goes to SELECT with ch=0 instead of IDLE.
  - o_busy stays 1 and scanning repeats indefinitely after the first accepted i_start.
  - o_valid pulses every 4·(SETTLE_CYC+1)+1 cycles.
  - Only i_rst stops scanning.
- Undefined: single-shot behaviour as in Operation.

## Test plan
- Reset: assert i_rst asynchronously mid-clock.
  - Required: outputs are at reset values without waiting for a clock edge (B=A=0, strobes=1, data=0, valid=0, busy=0).
- Basic scan, SETTLE_CYC=2, behavioural LS153 attached, 1C3..1C0=1010, 2C3..2C0=0110, pulse i_start.
  - Required: o_valid high exactly 12 cycles after E0, o_data1=4'b1010, o_data2=4'b0110.
  - Required: select sequence 00,01,10,11.
  - Required: strobes high on every select change.
- Settle boundary, SETTLE_CYC=1, change 1C2 from 0 to 1 during the SELECT cycle of ch=2.
  - Required: o_data1[2]=1.
  - Required: valid arrives after 8 cycles.
- Start while busy: pulse i_start at cycle 5 of a scan and again in the DONE cycle.
  - Required: exactly one o_valid; FSM returns to IDLE.
- Reset mid-scan at ch=2 after a prior scan left o_data1=4'hF.
  - Required: o_data1=0, no o_valid, a fresh i_start completes normally.
- MUX_SCAN_AUTO_EN defined, SETTLE_CYC=2, one i_start.
  - Required: o_valid pulses at period 13 for at least 3 scans.
  - Required: o_busy stays 1 and tracks input changes between scans.
